// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read/write transaction arbiters.
// rr_pick is sized for the largest supported master count so both arbiters can reuse it.
package axi_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_e;

  localparam int STAT_W = 16;
  localparam int MAX_M  = 8;
  localparam int PTR_W  = 3;

  // One-hot winner: first set bit of req scanning from ptr+1 upward, wrapping modulo n.
  // The scan runs in reverse order so the candidate nearest ptr+1 is written last and wins.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                              input logic [PTR_W-1:0] ptr,
                                              input int n);
    logic [MAX_M-1:0] win;
    logic [PTR_W-1:0] sel;
    win = '0;
    for (int k = MAX_M; k >= 1; k--) begin
      if (k <= n) begin
        sel = PTR_W'((int'(ptr) + k) % n);
        if (req[sel]) begin
          win      = '0;
          win[sel] = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin priority encoder: one-hot winner, its index and an any-request flag.
module rr_prio_enc
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM_M-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_M-1:0] pick;

  always_comb begin
    pick   = rr_pick(MAX_M'(req), PTR_W'(ptr), NUM_M);
    onehot = pick[NUM_M-1:0];
    any    = |pick;
    idx    = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/axi_arbiter_rd.sv
// Burst-level round-robin arbiter for the shared AXI read path (AR + R).
// Optional per-master burst counters are enabled with the macro AXI_ARB_RD_STAT_EN.
module axi_arbiter_rd
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic             s_arready,
  input  logic             s_rvalid,
  input  logic             s_rready,
  input  logic             s_rlast,
  output logic [NUM_M-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
`ifdef AXI_ARB_RD_STAT_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_M*STAT_W-1:0] stat_bursts
`endif
);

  arb_state_e       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] enc_ptr;
  logic [NUM_M-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             burst_done;

  assign burst_done = (state_reg == ARB_DATA) && s_rvalid && s_rready && s_rlast;

  // On completion the pointer moves to the finishing master in the same cycle it re-arbitrates.
  assign enc_ptr = (state_reg == ARB_DATA) ? grant_idx : rr_ptr_reg;

  rr_prio_enc #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_enc (
    .req    (m_arvalid),
    .ptr    (enc_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg  <= ARB_IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      rr_ptr_reg <= IDX_W'(NUM_M - 1);
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (win_any) begin
            grant     <= win_onehot;
            grant_idx <= win_idx;
            busy      <= 1'b1;
            state_reg <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          // R-channel activity is ignored here: no burst has been issued yet.
          if (m_arvalid[grant_idx] && s_arready) state_reg <= ARB_DATA;
        end
        ARB_DATA: begin
          if (burst_done) begin
            rr_ptr_reg <= grant_idx;
            if (win_any) begin
              grant     <= win_onehot;
              grant_idx <= win_idx;
              state_reg <= ARB_ADDR;
            end else begin
              grant     <= '0;
              busy      <= 1'b0;
              state_reg <= ARB_IDLE;
            end
          end
        end
        default: begin
          grant     <= '0;
          busy      <= 1'b0;
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_ARB_RD_STAT_EN
  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        cnt_reg <= '0;
      end else if (stat_clr) begin
        cnt_reg <= '0;
      end else if (burst_done && (grant_idx == IDX_W'(gi)) && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign stat_bursts[gi*STAT_W +: STAT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_axi_arbiter_rd.sv
// Self-checking bench for axi_arbiter_rd; burst-counter test runs when AXI_ARB_RD_STAT_EN is defined.
module tb_axi_arbiter_rd;

  localparam int NUM_M = 4;
  localparam int IDX_W = 2;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [NUM_M-1:0] m_arvalid;
  logic             s_arready, s_rvalid, s_rready, s_rlast;
  logic [NUM_M-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             stat_clr;
`ifdef AXI_ARB_RD_STAT_EN
  logic [NUM_M*16-1:0] stat_bursts;
`endif

  int checks   = 0;
  int failures = 0;
  logic [NUM_M-1:0] exp_q[$];
  logic [NUM_M-1:0] exp_g;

  always #5 ACLK = ~ACLK;

  axi_arbiter_rd #(.NUM_M(NUM_M), .IDX_W(IDX_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m_arvalid (m_arvalid),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rlast   (s_rlast),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef AXI_ARB_RD_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_bursts (stat_bursts)
`endif
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // AR handshake for the granted master, then 'beats' R beats; m_arvalid becomes next_req after AR.
  task automatic run_burst(input int beats, input logic [NUM_M-1:0] next_req, input logic clr);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid = next_req;
    for (int b = 0; b < beats; b++) begin
      s_rvalid = 1'b1;
      s_rready = 1'b1;
      s_rlast  = (b == beats - 1);
      stat_clr = clr && (b == beats - 1);
      tick();
    end
    s_rvalid = 1'b0;
    s_rready = 1'b0;
    s_rlast  = 1'b0;
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; m_arvalid = '0; s_arready = 0; s_rvalid = 0; s_rready = 0; s_rlast = 0; stat_clr = 0;
    #3;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant actual=%b required=%b", grant, 4'b0000); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_idx actual=%0d required=0", grant_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    m_arvalid = 4'b0101;
    exp_q.push_back(4'b0001);
    tick();
    exp_g = exp_q.pop_front();
    checks++; if (grant !== exp_g) begin failures++; $display("FAIL first_grant actual=%b required=%b", grant, exp_g); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL first_idx actual=%0d required=0", grant_idx); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_busy actual=%b required=1", busy); end
    $display("test_reset: grant=%b idx=%0d busy=%b", grant, grant_idx, busy);
  endtask

  task automatic test_burst_hold();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rready = 1'b1; s_rlast = (b == 3);
      if (b == 3) exp_q.push_back(4'b0100);
      else        exp_q.push_back(4'b0001);
      tick();
      exp_g = exp_q.pop_front();
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL burst_beat%0d_grant actual=%b required=%b", b, grant, exp_g); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_beat%0d_busy actual=%b required=1", b, busy); end
    end
    s_rvalid = 0; s_rready = 0; s_rlast = 0;
    checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL b2b_idx actual=%0d required=2", grant_idx); end
    $display("test_burst_hold: grant=%b idx=%0d busy=%b", grant, grant_idx, busy);
  endtask

  task automatic test_idle_ptr();
    run_burst(1, 4'b0000, 1'b0);
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_done actual=%b/%b required=0000/0", grant, busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL idle_hold%0d actual=%b required=0000", c, grant); end
    end
    m_arvalid = 4'b0011;
    exp_q.push_back(4'b0001);
    tick();
    exp_g = exp_q.pop_front();
    checks++; if (grant !== exp_g) begin failures++; $display("FAIL idle_ptr_grant actual=%b required=%b", grant, exp_g); end
    $display("test_idle_ptr: grant=%b idx=%0d", grant, grant_idx);
  endtask

  task automatic test_round_robin();
    int cnt[NUM_M];
    logic [NUM_M-1:0] nxt;
    for (int i = 0; i < NUM_M; i++) cnt[i] = 0;
    m_arvalid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      nxt = '0;
      nxt[(k + 1) % NUM_M] = 1'b1;
      exp_q.push_back(nxt);
      run_burst(1, 4'b1111, 1'b0);
      exp_g = exp_q.pop_front();
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr%0d_grant actual=%b required=%b", k, grant, exp_g); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr%0d_busy actual=%b required=1", k, busy); end
      for (int i = 0; i < NUM_M; i++) if (grant[i]) cnt[i]++;
      $display("test_round_robin: burst %0d grant=%b idx=%0d", k, grant, grant_idx);
    end
    for (int i = 0; i < NUM_M; i++) begin
      checks++; if (cnt[i] != 2) begin failures++; $display("FAIL rr_share_m%0d actual=%0d required=2", i, cnt[i]); end
    end
  endtask

  task automatic test_ar_rlast_same_cycle();
    m_arvalid = 4'b0001;
    s_arready = 1; s_rvalid = 1; s_rready = 1; s_rlast = 1;
    tick();
    s_arready = 0; s_rvalid = 0; s_rready = 0; s_rlast = 0;
    m_arvalid = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL ar_rlast_hold actual=%b/%b required=0001/1", grant, busy); end
    s_rvalid = 1; s_rready = 1; s_rlast = 1;
    tick();
    s_rvalid = 0; s_rready = 0; s_rlast = 0;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL ar_rlast_done actual=%b/%b required=0000/0", grant, busy); end
    $display("test_ar_rlast_same_cycle: grant=%b busy=%b", grant, busy);
  endtask

  task automatic test_reset_mid_burst();
    m_arvalid = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL mid_pre_grant actual=%b required=0010", grant); end
    s_arready = 1; tick(); s_arready = 0; m_arvalid = 4'b0000;
    s_rvalid = 1; s_rready = 1; s_rlast = 0;
    tick();
    #2 ARESET = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mid_reset_grant actual=%b required=0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy actual=%b required=0", busy); end
    s_rvalid = 0; s_rready = 0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    m_arvalid = 4'b1000;
    exp_q.push_back(4'b1000);
    tick();
    exp_g = exp_q.pop_front();
    checks++; if (grant !== exp_g) begin failures++; $display("FAIL post_reset_grant actual=%b required=%b", grant, exp_g); end
    checks++; if (grant_idx !== 2'd3) begin failures++; $display("FAIL post_reset_idx actual=%0d required=3", grant_idx); end
    $display("test_reset_mid_burst: grant=%b idx=%0d", grant, grant_idx);
  endtask

`ifdef AXI_ARB_RD_STAT_EN
  task automatic test_stats();
    checks++; if (stat_bursts !== 64'd0) begin failures++; $display("FAIL stat_reset actual=%h required=0", stat_bursts); end
    m_arvalid = 4'b1010;
    run_burst(1, 4'b0010, 1'b0);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL stat_grant_m1 actual=%b required=0010", grant); end
    for (int k = 0; k < 3; k++) run_burst(2, 4'b0010, 1'b0);
    checks++; if (stat_bursts[31:16] !== 16'd3) begin failures++; $display("FAIL stat_m1 actual=%0d required=3", stat_bursts[31:16]); end
    checks++; if (stat_bursts[63:48] !== 16'd1) begin failures++; $display("FAIL stat_m3 actual=%0d required=1", stat_bursts[63:48]); end
    run_burst(1, 4'b0000, 1'b1);
    checks++; if (stat_bursts[31:16] !== 16'd0) begin failures++; $display("FAIL stat_clr_m1 actual=%0d required=0", stat_bursts[31:16]); end
    $display("test_stats: stat_bursts=%h", stat_bursts);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst_hold();
    test_idle_ptr();
    test_round_robin();
    test_ar_rlast_same_cycle();
    test_reset_mid_burst();
`ifdef AXI_ARB_RD_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_rd.md
Name: axi_arbiter_rd

Overview:
- Transaction-level round-robin arbiter for the shared AXI read path (AR + R channels) between NUM_M masters and one slave port of the interconnect.
- Grants one master per read burst: grant locks at arbitration, holds through the AR handshake and all R beats, and releases on the RLAST handshake.
- Drives a registered one-hot grant and an index that steer the interconnect's AR/R muxes; carries no data itself.

Parameters:
- NUM_M, 4, number of requesting masters (2..8).
- IDX_W, $clog2(NUM_M), width of the grant index.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; one clock; reset is asynchronous and active-high.
- m_arvalid  in  NUM_M  per-master ARVALID (request).
- s_arready  in  1  ARREADY from the shared slave.
- s_rvalid  in  1  RVALID from the shared slave.
- s_rready  in  1  RREADY of the currently granted master, already muxed.
- s_rlast  in  1  RLAST from the shared slave.
- grant  out  NUM_M  one-hot grant; all-zero when idle.
- grant_idx  out  IDX_W  encoded index of the granted master; holds its last value when idle.
- busy  out  1  high in ADDR or DATA.

Behaviour:
- Reset values: state=IDLE, grant=0, grant_idx=0, busy=0, rr_ptr=NUM_M-1 so master 0 has top priority first.
- All outputs are registered; grant changes only on an ACLK edge.
- Arbitration function: choose the first set bit of m_arvalid, scanning from rr_ptr+1 upward with wrap modulo NUM_M. rr_ptr's own bit is scanned last.
- IDLE:
  - If any m_arvalid is set, load grant/grant_idx with the winner and go to ADDR.
  - Latency is 1 cycle from request to grant.
- ADDR:
  - Grant is held.
  - When m_arvalid[grant_idx] && s_arready, go to DATA.
  - Requests from other masters are ignored.
  - A granted master dropping ARVALID is an AXI violation. The arbiter keeps the grant and stays in ADDR.
- DATA:
  - Grant is held through every beat.
  - On s_rvalid && s_rready && s_rlast, set rr_ptr=grant_idx and arbitrate in the same cycle, using the updated pointer.
  - If any m_arvalid is set, load the new grant and go to ADDR. There is no idle bubble between bursts.
  - Otherwise clear grant and go to IDLE.
  - Beats without RLAST, or without both valid and ready, do not change state.
- rr_ptr updates only on burst completion. An idle period does not move it.
- Simultaneous AR handshake and RLAST in the same ADDR cycle: only the AR handshake is honoured, because a burst cannot finish before it has been issued.
- ARESET asserted mid-burst: immediate asynchronous return to reset values. The slave side is also reset by the system; no beat completion is tracked.
- Only one burst is in flight at a time; outstanding depth is 1 by design.

Optional Feature:
- Macro: AXI_ARB_RD_STAT_EN.
- With the macro defined, added ports:
  - stat_bursts out NUM_M*16: per-master saturating 16-bit counters of completed bursts.
  - stat_clr in 1: synchronous clear; clear has priority over increment.
  - Each counter increments on its master's RLAST handshake and saturates at 16'hFFFF.
  - Counters reset to 0 on ARESET.
- Without the macro, the stat ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package axi_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_e;
  - the constant STAT_W=16;
  - a function rr_pick(req, ptr) returning a one-hot winner, shared with the future write arbiter.
- One sub-module is natural: rr_prio_enc, a combinational rotate–priority-encode–rotate-back yielding one-hot plus index.

Test Plan:
- Reset, then m_arvalid=4'b0101 at cycle 0 → grant=4'b0001 and grant_idx=0 at cycle 1, busy=1.
- Master 0 burst of 4 beats (RLAST on beat 4) with m_arvalid=4'b0101 held → on the RLAST cycle+1, grant=4'b0100 with no IDLE cycle between.
- All four masters request continuously, each burst 1 beat → grant order 0,1,2,3,0 and each master gets exactly 1 burst per 4.
- Master 2 completes, then requests 4'b0000 for 3 cycles, then 4'b0011 → grant=4'b0001, since rr_ptr stays 2 and scanning starts at 3.
- ARESET pulsed during DATA beat 2 of 8 → grant=0 and busy=0 asynchronously. The next request from master 3 alone gives grant=4'b1000 one cycle later.
- With AXI_ARB_RD_STAT_EN: 3 bursts by master 1 → stat_bursts[31:16]=3; stat_clr asserted together with a master 1 RLAST → the counter reads 0.
